// File: rtl/store_drain_unit.sv
// Store buffer between the store reservation station and the data cache: accepts committed
// stores into an in-order FIFO and drains them one write per cycle. Define STB_FWD_EN for load forwarding.
module store_drain_unit #(
    parameter int SB_DEPTH = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      st_valid,
    input  logic [ADDR_W-1:0]         st_pkt_addr,
    input  logic [DATA_W-1:0]         st_pkt_data,
    input  logic [2:0]                st_pkt_funct3,
    output logic                      st_ready,
    output logic                      dc_req_valid,
    output logic [ADDR_W-1:0]         dc_req_addr,
    output logic [DATA_W-1:0]         dc_req_wdata,
    output logic [DATA_W/8-1:0]       dc_req_be,
    input  logic                      cache_stall,
    output logic                      misalign_err,
    output logic [$clog2(SB_DEPTH):0] sb_count,
    output logic                      sb_empty
`ifdef STB_FWD_EN
    ,
    input  logic [ADDR_W-1:0]         ld_addr,
    output logic                      fwd_hit,
    output logic [DATA_W-1:0]         fwd_data,
    output logic [DATA_W/8-1:0]       fwd_be
`endif
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BE_W  = DATA_W / 8;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [ADDR_W-1:0] addr_mem_q [SB_DEPTH];
    logic [DATA_W-1:0] data_mem_q [SB_DEPTH];
    logic [BE_W-1:0]   be_mem_q   [SB_DEPTH];

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [0:0]        state_q, state_d;
    logic              misalign_q, misalign_d;

    logic [1:0]        off;
    logic [ADDR_W-1:0] enc_addr;
    logic [DATA_W-1:0] enc_wdata;
    logic [BE_W-1:0]   enc_be;
    logic              enc_misalign;
    logic              full, push, pop;

    // Lane placement happens at enqueue so the drain path is a plain register read.
    always_comb begin
        off      = st_pkt_addr[1:0];
        enc_addr = {st_pkt_addr[ADDR_W-1:2], 2'b00};
        case (st_pkt_funct3)
            3'b000: begin
                enc_be       = BE_W'(1) << off;
                enc_wdata    = {BE_W{st_pkt_data[7:0]}};
                enc_misalign = 1'b0;
            end
            3'b001: begin
                enc_be       = BE_W'(3) << {off[1], 1'b0};
                enc_wdata    = {(DATA_W/16){st_pkt_data[15:0]}};
                enc_misalign = off[0];
            end
            default: begin
                enc_be       = '1;
                enc_wdata    = st_pkt_data;
                enc_misalign = (off != 2'b00);
            end
        endcase
    end

    // Fullness comes from the registered count only, so a same-cycle pop never frees a slot.
    always_comb begin
        full     = (count_q == CNT_W'(SB_DEPTH));
        st_ready = !full && !flush && !rst;
        push     = st_valid && st_ready;
        pop      = (state_q == S_REQ) && !cache_stall;

        count_d = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);

        head_d     = pop  ? head_q + PTR_W'(1) : head_q;
        tail_d     = push ? tail_q + PTR_W'(1) : tail_q;
        misalign_d = push && enc_misalign;

        state_d = state_q;
        case (state_q)
            S_IDLE:  if (count_d != '0) state_d = S_REQ;
            S_REQ:   if (pop && count_d == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            misalign_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            state_q    <= state_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[tail_q] <= enc_addr;
            data_mem_q[tail_q] <= enc_wdata;
            be_mem_q[tail_q]   <= enc_be;
        end
    end

    assign dc_req_valid = (state_q == S_REQ);
    assign dc_req_addr  = addr_mem_q[head_q];
    assign dc_req_wdata = data_mem_q[head_q];
    assign dc_req_be    = be_mem_q[head_q];
    assign misalign_err = misalign_q;
    assign sb_count     = count_q;
    assign sb_empty     = (count_q == '0);

`ifdef STB_FWD_EN
    logic unused_ld_lo;
    assign unused_ld_lo = ^ld_addr[1:0];

    // Walk from oldest to youngest so the youngest matching entry overrides earlier hits.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_be   = '0;
        for (int i = SB_DEPTH - 1; i >= 0; i--) begin
            logic [PTR_W-1:0] idx;
            idx = tail_q - PTR_W'(i) - PTR_W'(1);
            if (CNT_W'(i) < count_q && addr_mem_q[idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem_q[idx];
                fwd_be   = be_mem_q[idx];
            end
        end
    end
`endif
endmodule
